enemy_formation_ctrl: RTL and testbench

//  Sequences the enemy formation by generating the per-frame velocity pair consumed by the enemy block.

---
 rtl/enemy_formation_ctrl.sv | 173 +++++++++++++++++
 tb/tb_enemy_formation_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_formation_ctrl.sv
// Enemy formation sequencer: per-frame velocity pair for the enemy block,
// running idle -> entry descent -> left/right sway with pauses at each extreme.
module enemy_formation_ctrl #(
  parameter int EnterFrames = 60,
  parameter int EnterStep   = 2,
  parameter int SwayStep    = 1,
  parameter int SwayLimit   = 32,
  parameter int PauseFrames = 30
) (
  input  logic       frame_clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       freeze_i,
  output logic [9:0] xvel_o,
  output logic [9:0] yvel_o,
  output logic [9:0] xoff_o,
  output logic [9:0] yoff_o,
  output logic [2:0] state_o,
  output logic       in_formation_o,
  output logic [7:0] wave_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    SWAY_R  = 3'd2,
    PAUSE_R = 3'd3,
    SWAY_L  = 3'd4,
    PAUSE_L = 3'd5
  } state_t;

  localparam logic signed [9:0] ENTER_V    = 10'(EnterStep);
  localparam logic signed [9:0] SWAY_V     = 10'(SwayStep);
  localparam logic signed [9:0] LIMIT      = 10'(SwayLimit);
  localparam logic [7:0]        ENTER_LAST = 8'(EnterFrames - 1);
  localparam logic [7:0]        PAUSE_LAST = 8'(PauseFrames - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic signed [9:0] xvel, xvel_n, yvel, yvel_n;
  logic signed [9:0] xoff, xoff_n, yoff, yoff_n, xnext;
  logic [7:0]        wave, wave_n;
  logic              held, held_n;
  logic              in_form, in_form_n;

  function automatic logic signed [9:0] state_xvel(input state_t s);
    case (s)
      SWAY_R:  state_xvel = SWAY_V;
      SWAY_L:  state_xvel = -SWAY_V;
      default: state_xvel = '0;
    endcase
  endfunction

  function automatic logic signed [9:0] state_yvel(input state_t s);
    state_yvel = (s == ENTER) ? ENTER_V : '0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // held marks the first unfrozen edge: it only restores velocity, so the
  // zero-velocity frames never advance cnt or the sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    xvel_n  = xvel;
    yvel_n  = yvel;
    xoff_n  = xoff;
    yoff_n  = yoff;
    wave_n  = wave;
    held_n  = held;
    xnext   = xoff + xvel;
    if (clear_i) begin
      if (state != IDLE) begin
        state_n = IDLE;
        cnt_n   = '0;
        xvel_n  = '0;
        yvel_n  = '0;
        held_n  = 1'b0;
        wave_n  = sat_inc(wave);
      end
    end else if (freeze_i) begin
      xvel_n = '0;
      yvel_n = '0;
      held_n = (state != IDLE);
    end else if (held) begin
      held_n = 1'b0;
      xvel_n = state_xvel(state);
      yvel_n = state_yvel(state);
    end else if (state == IDLE) begin
      if (start_i) begin
        state_n = ENTER;
        cnt_n   = '0;
        xoff_n  = '0;
        yoff_n  = '0;
        xvel_n  = state_xvel(ENTER);
        yvel_n  = state_yvel(ENTER);
      end
    end else begin
      xoff_n = xnext;
      yoff_n = yoff + yvel;
      case (state)
        ENTER: begin
          if (cnt == ENTER_LAST) begin
            state_n = SWAY_R;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        SWAY_R: begin
          if (xnext == LIMIT) begin
            state_n = PAUSE_R;
            cnt_n   = '0;
          end
        end
        SWAY_L: begin
          if (xnext == -LIMIT) begin
            state_n = PAUSE_L;
            cnt_n   = '0;
          end
        end
        PAUSE_R, PAUSE_L: begin
          if (cnt == PAUSE_LAST) begin
            state_n = (state == PAUSE_R) ? SWAY_L : SWAY_R;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
      xvel_n = state_xvel(state_n);
      yvel_n = state_yvel(state_n);
    end
    in_form_n = (state_n != IDLE) && (state_n != ENTER);
  end

  always_ff @(posedge frame_clk_i) begin
    if (!reset_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      xvel    <= '0;
      yvel    <= '0;
      xoff    <= '0;
      yoff    <= '0;
      wave    <= '0;
      held    <= 1'b0;
      in_form <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      xvel    <= xvel_n;
      yvel    <= yvel_n;
      xoff    <= xoff_n;
      yoff    <= yoff_n;
      wave    <= wave_n;
      held    <= held_n;
      in_form <= in_form_n;
    end
  end

  assign xvel_o         = xvel;
  assign yvel_o         = yvel;
  assign xoff_o         = xoff;
  assign yoff_o         = yoff;
  assign state_o        = state;
  assign in_formation_o = in_form;
  assign wave_o         = wave;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Bench for enemy_formation_ctrl: directed scenarios with literal expectations,
// then random start/clear/freeze/reset traffic against a frame-level model.
module tb_enemy_formation_ctrl;

  localparam int EF = 4;
  localparam int ES = 2;
  localparam int SS = 1;
  localparam int SL = 3;
  localparam int PF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] xvel, yvel, xoff, yoff;
  logic [2:0] state;
  logic       infm;
  logic [7:0] wave;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 entering, 2 right, 3 pause right, 4 left, 5 pause left
  int m_mode = 0, m_vx = 0, m_vy = 0, m_ox = 0, m_oy = 0, m_wave = 0;
  int m_frames = 0, m_next = 0;
  bit m_held = 1'b0;

  enemy_formation_ctrl #(
    .EnterFrames(EF), .EnterStep(ES), .SwayStep(SS), .SwayLimit(SL), .PauseFrames(PF)
  ) dut (
    .frame_clk_i(clk), .reset_ni(rst_n), .start_i(start), .clear_i(clear),
    .freeze_i(freeze), .xvel_o(xvel), .yvel_o(yvel), .xoff_o(xoff), .yoff_o(yoff),
    .state_o(state), .in_formation_o(infm), .wave_o(wave)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  function automatic int mvx(input int mode);
    if (mode == 2) return SS;
    if (mode == 4) return -SS;
    return 0;
  endfunction

  function automatic int mvy(input int mode);
    return (mode == 1) ? ES : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_vx = 0; m_vy = 0; m_ox = 0; m_oy = 0; m_wave = 0;
      m_frames = 0; m_held = 1'b0;
    end else if (clear) begin
      if (m_mode != 0) begin
        m_mode = 0; m_vx = 0; m_vy = 0; m_frames = 0; m_held = 1'b0;
        if (m_wave < 255) m_wave++;
      end
    end else if (freeze) begin
      m_vx = 0; m_vy = 0;
      if (m_mode != 0) m_held = 1'b1;
    end else if (m_held) begin
      m_held = 1'b0;
      m_vx = mvx(m_mode); m_vy = mvy(m_mode);
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_frames = 0; m_ox = 0; m_oy = 0;
        m_vx = mvx(1); m_vy = mvy(1);
      end
    end else begin
      m_ox += m_vx;
      m_oy += m_vy;
      m_frames++;
      m_next = m_mode;
      case (m_mode)
        1: if (m_frames == EF) m_next = 2;
        2: if (m_ox == SL) m_next = 3;
        3: if (m_frames == PF) m_next = 4;
        4: if (m_ox == -SL) m_next = 5;
        5: if (m_frames == PF) m_next = 2;
        default: m_next = 0;
      endcase
      if (m_next != m_mode) begin
        m_mode = m_next;
        m_frames = 0;
      end
      m_vx = mvx(m_mode); m_vy = mvy(m_mode);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state", int'(state), m_mode);
      check("m_xvel", sx(xvel), m_vx);
      check("m_yvel", sx(yvel), m_vy);
      check("m_xoff", sx(xoff), m_ox);
      check("m_yoff", sx(yoff), m_oy);
      check("m_infm", int'(infm), (m_mode >= 2) ? 1 : 0);
      check("m_wave", int'(wave), m_wave);
    end
  end

  task automatic step(input bit s, input bit c, input bit f);
    start = s; clear = c; freeze = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_x[14];
    int xmax, xmin;
    bit found;
    exp_x = '{1, 1, 1, 0, 0, -1, -1, -1, -1, -1, -1, 0, 0, 1};

    rst_n = 1'b0;
    step(1, 0, 0);
    step(1, 0, 0);
    chk_en = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_wave", int'(wave), 0);
    check("rst_yvel", sx(yvel), 0);

    rst_n = 1'b1;
    step(1, 0, 0);
    check("start_state", int'(state), 1);
    check("enter_yvel0", sx(yvel), 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("enter_yvel", sx(yvel), 2);
    end
    step(0, 0, 0);
    check("enter_done_yvel", sx(yvel), 0);
    check("enter_done_yoff", sx(yoff), 8);
    check("enter_done_state", int'(state), 2);

    xmax = -1000; xmin = 1000;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) step(0, 0, 0);
      check("sway_xvel", sx(xvel), exp_x[i]);
      if (sx(xoff) > xmax) xmax = sx(xoff);
      if (sx(xoff) < xmin) xmin = sx(xoff);
    end
    check("sway_peak_pos", xmax, 3);
    check("sway_peak_neg", xmin, -3);

    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (int'(state) == 4 && sx(xoff) == 1) found = 1'b1;
      else step(0, 0, 0);
    end
    check("find_swayl_x1", int'(found), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      check("frz_xvel", sx(xvel), 0);
      check("frz_xoff", sx(xoff), 1);
    end
    step(0, 0, 0);
    check("unfrz_xvel", sx(xvel), -1);
    check("unfrz_xoff", sx(xoff), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("unfrz_reach_xoff", sx(xoff), -3);
    check("unfrz_reach_state", int'(state), 5);

    rst_n = 1'b0;
    step(1, 0, 0);
    step(1, 0, 0);
    check("midrst_state", int'(state), 0);
    check("midrst_xoff", sx(xoff), 0);
    check("midrst_yoff", sx(yoff), 0);
    check("midrst_infm", int'(infm), 0);
    rst_n = 1'b1;

    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    check("clr_state", int'(state), 0);
    check("clr_yvel", sx(yvel), 0);
    check("clr_wave", int'(wave), 1);
    check("clr_yoff_hold", sx(yoff), 2);
    step(0, 0, 0);
    check("clr_stay_idle", int'(state), 0);
    step(1, 0, 0);
    check("restart_state", int'(state), 1);
    check("restart_yoff", sx(yoff), 0);
    check("restart_xoff", sx(xoff), 0);

    for (int i = 0; i < 260; i++) begin
      step(0, 1, 0);
      step(1, 0, 0);
    end
    check("wave_sat", int'(wave), 255);
    step(0, 1, 0);
    check("wave_sat_hold", int'(wave), 255);
    step(1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (int'(state) == 2) found = 1'b1;
      else step(0, 0, 0);
    end
    check("find_swayr", int'(found), 1);
    step(1, 0, 0);
    check("start_in_sway", int'(state), 2);
    check("start_in_sway_xvel", sx(xvel), 1);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0));
    end
    rst_n = 1'b1;
    step(0, 0, 0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
